uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART serial transmit line among NUM_REQ byte requesters.
- Round-robin arbitration, one byte per frame.
- Frame format, LSB-first: start (0), 8 data bits, parity, stop (1). This matches the frame our receiver state machine expects.
- Contains its own bit-period counter, the frame sequencer and the grant pointer.
- Sits between on-chip byte producers (command/status sources) and the pad-level tx line.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- CLKS_PER_BIT, 16: clk cycles per serial bit, >=2.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  requester i byte at bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot accept strobe.
- tx_out  out  1  serial line, idle high.
- busy  out  1  high from START entry until the frame returns to IDLE.
- grant_id  out  clog2(NUM_REQ)  index of the last accepted requester.
- frame_done  out  1  one-cycle pulse on the final STOP cycle.

Behaviour:
- Reset values: tx_out=1, req_ready=0, busy=0, grant_id=0, frame_done=0, bit counter=0, state=IDLE.
  - Round-robin pointer resets to NUM_REQ-1, so req0 wins first.
- States: IDLE, START, DATA, PARITY, STOP.
- Each state other than IDLE holds tx_out for exactly CLKS_PER_BIT cycles, timed by a clock counter.
  - DATA repeats 8 times; a 3-bit index selects data bit 0..7.
- IDLE:
  - tx_out=1.
  - If any req_valid: pick the winner g = first valid index searching from pointer+1, wrapping modulo NUM_REQ.
  - req_ready[g]=1 combinationally in that same cycle.
  - Latch req_data[g] and the computed parity bit; set grant_id=g and pointer=g; next state START.
  - If no req_valid: stay in IDLE.
- Transfer rule:
  - A byte is accepted when req_valid&req_ready.
  - Requesters hold valid/data stable until accepted.
  - Requests arriving during a frame wait; they are only sampled in IDLE.
- Parity:
  - Even: bit = XOR of the 8 data bits.
  - Odd: inverted XOR.
  - Computed on the accepted byte.
- Sequence after acceptance:
  - START: tx_out=0.
  - DATA: tx_out = data[0..7].
  - PARITY: tx_out = parity bit.
  - STOP: tx_out=1.
  - Then IDLE.
- Timing:
  - Frame length is 11*CLKS_PER_BIT cycles after the accept cycle.
  - frame_done is asserted on the last STOP cycle.
  - Back-to-back period is 11*CLKS_PER_BIT+1 cycles, which includes one IDLE arbitration cycle with tx high.
- tx_out is driven from a register: no glitches, and it changes only at bit boundaries.
- Reset mid-frame:
  - Next cycle tx_out=1, busy=0, state=IDLE, pointer reset.
  - No frame_done pulse; the partial byte is discarded.
- A requester that deasserts valid before being granted is simply skipped.
- Single requester continuously valid: it wins every IDLE cycle.

Optional Feature:
- Macro UART_TX_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest valid index wins. The pointer is not implemented; grant_id is still updated.
- Undefined: round-robin as specified above.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE/START/DATA/PARITY/STOP);
  - FRAME_BITS=11, DATA_BITS=8;
  - parity function (data, odd flag) -> bit.
- Sub-module uart_rr_arbiter:
  - combinational grant from valid vector + pointer;
  - outputs one-hot grant, encoded index and any_valid;
  - under the macro it reduces to a priority encoder.
- The top level keeps the sequencer, counters and data/parity registers.

Test Plan:
1. CLKS_PER_BIT=4, req1 sends 0x5A.
   - req_ready=0010 for one cycle, grant_id=1.
   - tx_out over 44 cycles: 0, 0,1,0,1,1,0,1,0, parity 0, 1 (each bit 4 cycles).
   - frame_done at cycle 44 after accept.
2. All four requesters held valid.
   - Accept order 0,1,2,3,0.
   - Accept strobes 45 cycles apart.
   - tx_out=1 during each IDLE cycle.
3. After a req0 grant, req0 and req2 both valid.
   - Next grant is 2, then 0.
   - req1/req3 ready never asserted.
4. Reset asserted during DATA bit 3.
   - Next cycle tx_out=1, busy=0, no frame_done.
   - With req0 and req3 valid after reset release, req0 is granted first.
5. PARITY_ODD=1, byte 0xFF: parity bit 1. Rebuilt with PARITY_ODD=0: parity bit 0. 0x01 with even parity: parity bit 1.
6. With UART_TX_ARB_FIXED_PRIO_EN defined, req0 and req3 continuously valid.
   - req3 is never granted over 5 frames.
   - After req0 drops, req3 is granted at the next IDLE.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types, constants and the parity helper for the UART transmit arbiter.
package uart_pkg;

  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned DATA_BITS  = 8;

  typedef enum logic [2:0] {
    UART_IDLE   = 3'd0,
    UART_START  = 3'd1,
    UART_DATA   = 3'd2,
    UART_PARITY = 3'd3,
    UART_STOP   = 3'd4
  } uart_state_e;

  // Even parity is the XOR of the data bits; odd parity inverts it.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational requester arbiter: round-robin from a pointer, or a plain
// lowest-index priority encoder when UART_TX_ARB_FIXED_PRIO_EN is defined.
module uart_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_valid,
`ifndef UART_TX_ARB_FIXED_PRIO_EN
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
`endif
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       any_valid
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  logic          found;
  logic [IW-1:0] idx;

  assign any_valid = |req_valid;

  // First valid requester in search order wins; search starts after the pointer.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = IW'(k);
`else
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((32'(ptr) + k) % NUM_REQ);
`endif
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART tx line among NUM_REQ byte requesters, one byte per frame
// (start, 8 data bits LSB-first, parity, stop). Define UART_TX_ARB_FIXED_PRIO_EN
// for fixed lowest-index priority instead of round-robin.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_out,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       frame_done
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE   = UART_IDLE;
  localparam logic [2:0] START  = UART_START;
  localparam logic [2:0] DATA   = UART_DATA;
  localparam logic [2:0] PARITY = UART_PARITY;
  localparam logic [2:0] STOP   = UART_STOP;

  logic [2:0]           state, state_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic [2:0]           bit_idx, bit_d;
  logic [DATA_BITS-1:0] data_q, data_d, grant_data;
  logic                 par_q, par_d;
  logic                 tx_d, frame_done_d, accept;
  logic [NUM_REQ-1:0]   grant;
  logic [IW-1:0]        grant_idx;
  logic                 any_valid;

`ifndef UART_TX_ARB_FIXED_PRIO_EN
  logic [IW-1:0] ptr;
`endif

  uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_valid (req_valid),
`ifndef UART_TX_ARB_FIXED_PRIO_EN
    .ptr       (ptr),
`endif
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  // Requests are only accepted while idle; the strobe is combinational.
  assign req_ready = (state == IDLE) ? grant : '0;

  // Byte of the current winner.
  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_data = req_data[8*i +: 8];
    end
  end

  // Frame sequencer next state plus next values of the registered outputs.
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    bit_d        = bit_idx;
    data_d       = data_q;
    par_d        = par_q;
    accept       = 1'b0;
    tx_d         = 1'b1;
    frame_done_d = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          accept  = 1'b1;
          state_d = START;
          cnt_d   = '0;
          bit_d   = '0;
          data_d  = grant_data;
          par_d   = parity_bit(grant_data, PARITY_ODD != 0);
        end
      end
      default: begin
        if (cnt == CNT_LAST) begin
          cnt_d = '0;
          case (state)
            START:  state_d = DATA;
            DATA: begin
              if (bit_idx == 3'(DATA_BITS - 1)) state_d = PARITY;
              else                              bit_d   = bit_idx + 3'd1;
            end
            PARITY: state_d = STOP;
            default: state_d = IDLE;
          endcase
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
    endcase
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[bit_d];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
    frame_done_d = (state_d == STOP) && (cnt_d == CNT_LAST);
  end

  // State, counters, latched byte and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      data_q     <= '0;
      par_q      <= 1'b0;
      tx_out     <= 1'b1;
      busy       <= 1'b0;
      grant_id   <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      bit_idx    <= bit_d;
      data_q     <= data_d;
      par_q      <= par_d;
      tx_out     <= tx_d;
      busy       <= (state_d != IDLE);
      frame_done <= frame_done_d;
      if (accept) grant_id <= grant_idx;
    end
  end

`ifndef UART_TX_ARB_FIXED_PRIO_EN
  // Round-robin pointer; reset value makes requester 0 win first.
  always_ff @(posedge clk) begin
    if (reset)       ptr <= IW'(NUM_REQ - 1);
    else if (accept) ptr <= grant_idx;
  end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter (CLKS_PER_BIT=4), plus an odd-parity instance.
module tb_uart_tx_arbiter;

  localparam int CB = 4;
  localparam int FL = 11 * CB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        tx_out, busy, frame_done;
  logic [1:0]  grant_id;

  logic [1:0]  o_valid = '0;
  logic [15:0] o_data = '0;
  logic [1:0]  o_ready;
  logic        o_tx, o_busy, o_done;
  logic [0:0]  o_gid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic rst_q = 1'b1;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .CLKS_PER_BIT(CB), .PARITY_ODD(0)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_out(tx_out), .busy(busy),
    .grant_id(grant_id), .frame_done(frame_done)
  );

  uart_tx_arbiter #(.NUM_REQ(2), .CLKS_PER_BIT(CB), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .reset(reset), .req_valid(o_valid), .req_data(o_data),
    .req_ready(o_ready), .tx_out(o_tx), .busy(o_busy),
    .grant_id(o_gid), .frame_done(o_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] d);
    return {1'b1, ^d, d, 1'b0};
  endfunction

  function automatic int model_grant(input logic [3:0] v, input int ptr);
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= 4; k++) begin
      int j = (ptr + k) % 4;
      if (v[j]) return j;
    end
`endif
    return -1;
  endfunction

  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    rst_q <= reset;
    cyc   <= cyc + 1;
  end

  // Reference model and scoreboard: expected frame pushed at accept, popped as it plays out.
  typedef struct packed { logic [10:0] bits; logic [1:0] id; } exp_t;
  exp_t expq[$];
  exp_t cur = '0;
  exp_t e;
  int m_pos = -1;
  int m_ptr = 3;
  int m_gid = 0;
  int g;

  always @(negedge clk) begin
    if (rst_q) begin
      chk("rst_tx", 32'(tx_out), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(frame_done), 0);
      chk("rst_gid", 32'(grant_id), 0);
      m_pos = -1; m_ptr = 3; m_gid = 0;
      expq.delete();
    end else if (m_pos < 0) begin
      chk("idle_tx", 32'(tx_out), 1);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_gid", 32'(grant_id), 32'(m_gid));
      g = model_grant(req_valid, m_ptr);
      chk("idle_ready", 32'(req_ready), (g >= 0) ? 32'(1 << g) : 0);
      if (g >= 0) begin
        e.id   = 2'(g);
        e.bits = frame_bits(req_data[8*g +: 8]);
        expq.push_back(e);
        m_ptr = g; m_gid = g; m_pos = 0;
      end
    end else begin
      if (m_pos == 0 && expq.size() > 0) cur = expq.pop_front();
      chk("frame_tx", 32'(tx_out), 32'(cur.bits[m_pos / CB]));
      chk("frame_busy", 32'(busy), 1);
      chk("frame_done", 32'(frame_done), (m_pos == FL - 1) ? 1 : 0);
      chk("frame_gid", 32'(grant_id), 32'(cur.id));
      chk("frame_ready", 32'(req_ready), 0);
      m_pos++;
      if (m_pos == FL) m_pos = -1;
    end
  end

  task automatic wait_ready(output logic [3:0] rdy);
    rdy = '0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (req_ready != 0) begin
        rdy = req_ready;
        return;
      end
    end
    chk("ready_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    chk("idle_timeout", 0, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // One byte from requester idx; records tx at bit centres and the frame_done cycle.
  task automatic send_one(input int idx, input logic [7:0] d, output logic [10:0] bits,
                          output int fd_k, output logic [3:0] rdy);
    @(posedge clk); #1;
    req_data[8*idx +: 8] = d;
    req_valid[idx] = 1'b1;
    wait_ready(rdy);
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
    bits = '0;
    fd_k = -1;
    for (int k = 1; k <= FL; k++) begin
      @(negedge clk);
      if ((k - 1) % CB == CB / 2) bits[(k - 1) / CB] = tx_out;
      if (frame_done) fd_k = k;
    end
  endtask

  logic [3:0]  r, acc;
  logic [10:0] bits;
  int          fd_k, id1, id2;
  int          ids[5];
  int          ts[5];
  int          exp2[5];
  int          exp6[5];
  logic        fd_seen;

  initial begin
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    exp2 = '{0, 0, 0, 0, 0};
    exp6 = '{0, 0, 0, 0, 0};
`else
    exp2 = '{0, 1, 2, 3, 0};
    exp6 = '{0, 3, 0, 3, 0};
`endif
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Odd parity instance: 0xFF gives parity bit 1
    o_data  = 16'h00FF;
    o_valid = 2'b01;
    begin : odd_wait
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (o_ready != 0) disable odd_wait;
      end
    end
    chk("odd_ready", 32'(o_ready), 32'h1);
    @(posedge clk); #1 o_valid = '0;
    repeat (38) @(negedge clk);
    chk("odd_parity_ff", 32'(o_tx), 1);

    // Single requester 1 sends 0x5A
    send_one(1, 8'h5A, bits, fd_k, r);
    chk("t1_ready", 32'(r), 32'b0010);
    chk("t1_bits", 32'(bits), 32'(11'b100_1011_0100));
    chk("t1_done_cycle", 32'(fd_k), 44);
    chk("t1_gid", 32'(grant_id), 1);

    // Even parity corner bytes
    send_one(2, 8'h01, bits, fd_k, r);
    chk("t5_parity_01", 32'(bits[9]), 1);
    send_one(1, 8'hFF, bits, fd_k, r);
    chk("t5_parity_ff", 32'(bits[9]), 0);

    // All four requesters held valid
    do_reset();
    req_data  = 32'h44332211;
    req_valid = 4'hF;
    for (int n = 0; n < 5; n++) begin
      wait_ready(r);
      ids[n] = oh2i(r);
      ts[n]  = cyc;
      chk("t2_accept_tx", 32'(tx_out), 1);
    end
    @(posedge clk); #1 req_valid = '0;
    wait_idle();
    for (int n = 0; n < 5; n++) chk("t2_order", 32'(ids[n]), 32'(exp2[n]));
    for (int n = 1; n < 5; n++) chk("t2_period", 32'(ts[n] - ts[n-1]), 45);

    // req0 granted, then req0 and req2 compete
    @(posedge clk); #1 req_valid = 4'b0001;
    wait_ready(r);
    chk("t3_first", 32'(r), 32'b0001);
    @(posedge clk); #1 req_valid = 4'b0101;
    acc = '0;
    wait_ready(r); acc |= r; id1 = oh2i(r);
    wait_ready(r); acc |= r; id2 = oh2i(r);
    @(posedge clk); #1 req_valid = '0;
    wait_idle();
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    chk("t3_second", 32'(id1), 0);
`else
    chk("t3_second", 32'(id1), 2);
`endif
    chk("t3_third", 32'(id2), 0);
    chk("t3_no_odd_reqs", 32'(acc & 4'b1010), 0);

    // Reset during data bit 3
    @(posedge clk); #1;
    req_data[7:0] = 8'hC3;
    req_valid = 4'b0001;
    wait_ready(r);
    @(posedge clk); #1 req_valid = '0;
    fd_seen = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      fd_seen |= frame_done;
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t4_tx", 32'(tx_out), 1);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_done", 32'(frame_done | fd_seen), 0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    req_data[31:24] = 8'h3C;
    req_valid = 4'b1001;
    wait_ready(r);
    chk("t4_after_reset", 32'(r), 32'b0001);
    @(posedge clk); #1 req_valid = '0;
    wait_idle();

    // req0 and req3 continuously valid, then req0 drops
    do_reset();
    req_data[7:0]   = 8'h81;
    req_data[31:24] = 8'h7E;
    req_valid = 4'b1001;
    for (int n = 0; n < 5; n++) begin
      wait_ready(r);
      ids[n] = oh2i(r);
    end
    @(posedge clk); #1 req_valid = 4'b1000;
    wait_ready(r);
    chk("t6_req3_after_drop", 32'(r), 32'b1000);
    @(posedge clk); #1 req_valid = '0;
    wait_idle();
    for (int n = 0; n < 5; n++) chk("t6_order", 32'(ids[n]), 32'(exp6[n]));

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
